pc_stack_unit: RTL and testbench

- Parametrised next-generation program counter. Supports sequential advance, absolute jump, PC-relative branch, and subroutine call/return through an internal return-address stack.
- Sits between the instruction fetch address mux and the decoder/branch unit.
- Drives the fetch address every cycle.
- Reports stack status and sticky error flags to the control/trap logic.

---
 rtl/pc_pkg.sv | 15 +
 rtl/pc_stack_unit_if.sv | 31 +++
 rtl/pc_ret_stack.sv | 52 +++++
 rtl/pc_stack_unit.sv | 102 ++++++++++
 tb/tb_pc_stack_unit.sv | 160 ++++++++++++++++
 5 files changed

// File: rtl/pc_pkg.sv
// Shared definitions for the program-counter / return-stack slice.
package pc_pkg;

    localparam int ADDR_W_DEF = 11;
    localparam int OFF_W_DEF  = 8;

    typedef logic [2:0] op_t;

    localparam op_t OP_NEXT = 3'd0;
    localparam op_t OP_JMP  = 3'd1;
    localparam op_t OP_BRR  = 3'd2;
    localparam op_t OP_CALL = 3'd3;
    localparam op_t OP_RET  = 3'd4;

endpackage

// File: rtl/pc_stack_unit_if.sv
// Control/status bundle between the fetch/decode side and the PC unit.
interface pc_stack_unit_if
    import pc_pkg::*;
#(
    parameter int ADDR_W      = ADDR_W_DEF,
    parameter int OFF_W       = OFF_W_DEF,
    parameter int STACK_DEPTH = 8
);
    logic                         adv;
    op_t                          op;
    logic [ADDR_W-1:0]            target;
    logic [OFF_W-1:0]             offset;
    logic                         clr_err;
    logic [ADDR_W-1:0]            pc;
    logic [$clog2(STACK_DEPTH):0] depth;
    logic                         stk_full;
    logic                         stk_empty;
    logic                         err_ovf;
    logic                         err_unf;

    modport master (
        output adv, op, target, offset, clr_err,
        input  pc, depth, stk_full, stk_empty, err_ovf, err_unf
    );

    modport slave (
        input  adv, op, target, offset, clr_err,
        output pc, depth, stk_full, stk_empty, err_ovf, err_unf
    );

endinterface

// File: rtl/pc_ret_stack.sv
// LIFO of return addresses; push while full and pop while empty are ignored.
module pc_ret_stack
    import pc_pkg::*;
#(
    parameter int ADDR_W      = ADDR_W_DEF,
    parameter int STACK_DEPTH = 8
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         push,
    input  logic                         pop,
    input  logic [ADDR_W-1:0]            din,
    output logic [ADDR_W-1:0]            top,
    output logic [$clog2(STACK_DEPTH):0] depth,
    output logic                         full,
    output logic                         empty
);
    localparam int PW = $clog2(STACK_DEPTH);
    localparam int DW = PW + 1;

    logic [ADDR_W-1:0] mem [STACK_DEPTH];
    logic [DW-1:0]     depth_q;
    logic [DW-1:0]     depth_m1;
    logic              do_push;
    logic              do_pop;

    assign full     = (depth_q == DW'(STACK_DEPTH));
    assign empty    = (depth_q == '0);
    assign do_push  = push && !full;
    assign do_pop   = pop && !empty && !do_push;
    assign depth_m1 = depth_q - DW'(1);
    assign top      = mem[depth_m1[PW-1:0]];
    assign depth    = depth_q;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            depth_q <= '0;
        end else if (do_push) begin
            depth_q <= depth_q + DW'(1);
        end else if (do_pop) begin
            depth_q <= depth_m1;
        end
    end

    // Entries carry no reset: contents are meaningless until pushed.
    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[depth_q[PW-1:0]] <= din;
        end
    end

endmodule

// File: rtl/pc_stack_unit.sv
// Program counter with sequential/jump/branch/call/return and sticky stack errors.
module pc_stack_unit
    import pc_pkg::*;
#(
    parameter int               ADDR_W      = ADDR_W_DEF,
    parameter int               OFF_W       = OFF_W_DEF,
    parameter int               STACK_DEPTH = 8,
    parameter logic [ADDR_W-1:0] RESET_VEC  = '0
) (
    input  logic            clk,
    input  logic            rst,
    pc_stack_unit_if.slave  bus
);
    logic [ADDR_W-1:0]            pc_q;
    logic [ADDR_W-1:0]            pc_nxt;
    logic [ADDR_W-1:0]            pc_inc;
    logic [ADDR_W-1:0]            pc_brr;
    logic [ADDR_W-1:0]            off_ext;
    logic [ADDR_W-1:0]            stk_top;
    logic [$clog2(STACK_DEPTH):0] stk_depth;
    logic                         stk_full;
    logic                         stk_empty;
    logic                         push;
    logic                         pop;
    logic                         set_ovf;
    logic                         set_unf;
    logic                         err_ovf_q;
    logic                         err_unf_q;

    assign off_ext = {{(ADDR_W-OFF_W){bus.offset[OFF_W-1]}}, bus.offset};
    assign pc_inc  = pc_q + ADDR_W'(1);
    assign pc_brr  = pc_q + off_ext;

    always_comb begin
        pc_nxt  = pc_q;
        push    = 1'b0;
        pop     = 1'b0;
        set_ovf = 1'b0;
        set_unf = 1'b0;
        if (bus.adv) begin
            case (bus.op)
                OP_JMP:  pc_nxt = bus.target;
                OP_BRR:  pc_nxt = pc_brr;
                OP_CALL: begin
                    if (stk_full) begin
                        pc_nxt  = pc_inc;
                        set_ovf = 1'b1;
                    end else begin
                        pc_nxt = bus.target;
                        push   = 1'b1;
                    end
                end
                OP_RET: begin
                    if (stk_empty) begin
                        pc_nxt  = pc_inc;
                        set_unf = 1'b1;
                    end else begin
                        pc_nxt = stk_top;
                        pop    = 1'b1;
                    end
                end
                default: pc_nxt = pc_inc;
            endcase
        end
    end

    pc_ret_stack #(
        .ADDR_W      (ADDR_W),
        .STACK_DEPTH (STACK_DEPTH)
    ) u_stack (
        .clk   (clk),
        .rst   (rst),
        .push  (push),
        .pop   (pop),
        .din   (pc_inc),
        .top   (stk_top),
        .depth (stk_depth),
        .full  (stk_full),
        .empty (stk_empty)
    );

    // Setting an error outranks clearing it in the same cycle.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            pc_q      <= RESET_VEC;
            err_ovf_q <= 1'b0;
            err_unf_q <= 1'b0;
        end else begin
            pc_q      <= pc_nxt;
            err_ovf_q <= set_ovf | (err_ovf_q & ~bus.clr_err);
            err_unf_q <= set_unf | (err_unf_q & ~bus.clr_err);
        end
    end

    assign bus.pc        = pc_q;
    assign bus.depth     = stk_depth;
    assign bus.stk_full  = stk_full;
    assign bus.stk_empty = stk_empty;
    assign bus.err_ovf   = err_ovf_q;
    assign bus.err_unf   = err_unf_q;

endmodule

// File: tb/tb_pc_stack_unit.sv
// Directed bench for pc_stack_unit with hand-computed expected values.
module tb_pc_stack_unit;
    import pc_pkg::*;

    logic clk;
    logic rst;
    int   total;
    int   bad;

    pc_stack_unit_if bus ();

    pc_stack_unit dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog obs=timeout exp=finish");
        $fatal(1, "watchdog expired");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        if (obs !== exp) begin
            bad++;
            $display("FAIL %s obs=%0h exp=%0h", tag, obs, exp);
        end
    endtask

    task automatic step(input logic a, input op_t o, input logic [10:0] t,
                        input logic [7:0] off, input logic c);
        bus.adv     = a;
        bus.op      = o;
        bus.target  = t;
        bus.offset  = off;
        bus.clr_err = c;
        @(posedge clk);
        #1;
    endtask

    task automatic chk_stat(input string tag, input logic [10:0] pc, input int dep,
                            input logic ovf, input logic unf);
        chk({tag, "_pc"}, 32'(bus.pc), 32'(pc));
        chk({tag, "_depth"}, 32'(bus.depth), 32'(dep));
        chk({tag, "_ovf"}, 32'(bus.err_ovf), 32'(ovf));
        chk({tag, "_unf"}, 32'(bus.err_unf), 32'(unf));
    endtask

    initial begin
        total = 0;
        bad   = 0;
        rst   = 1'b1;
        bus.adv = 1'b0; bus.op = OP_NEXT; bus.target = '0; bus.offset = '0; bus.clr_err = 1'b0;

        // asynchronous reset mid-cycle
        #2 rst = 1'b0;
        #1;
        chk_stat("rst", 11'h000, 0, 1'b0, 1'b0);
        chk("rst_empty", 32'(bus.stk_empty), 32'd1);
        chk("rst_full", 32'(bus.stk_full), 32'd0);
        @(negedge clk);
        rst = 1'b1;

        for (int i = 1; i <= 3; i++) begin
            step(1'b1, OP_NEXT, 11'h0, 8'h0, 1'b0);
            chk("next_seq", 32'(bus.pc), 32'(i));
        end

        step(1'b1, OP_JMP, 11'h7FF, 8'h0, 1'b0);
        chk("jmp_7ff", 32'(bus.pc), 32'h7FF);
        step(1'b1, OP_NEXT, 11'h0, 8'h0, 1'b0);
        chk("wrap_next", 32'(bus.pc), 32'h000);
        step(1'b1, OP_JMP, 11'h005, 8'h0, 1'b0);
        step(1'b1, OP_BRR, 11'h0, 8'hF8, 1'b0);
        chk("brr_neg", 32'(bus.pc), 32'h7FD);
        step(1'b1, OP_BRR, 11'h0, 8'h05, 1'b0);
        chk("brr_pos_wrap", 32'(bus.pc), 32'h002);

        step(1'b1, OP_JMP, 11'h010, 8'h0, 1'b0);
        step(1'b1, OP_CALL, 11'h100, 8'h0, 1'b0);
        chk_stat("call1", 11'h100, 1, 1'b0, 1'b0);
        step(1'b1, OP_CALL, 11'h200, 8'h0, 1'b0);
        chk_stat("call2", 11'h200, 2, 1'b0, 1'b0);
        step(1'b1, OP_RET, 11'h0, 8'h0, 1'b0);
        chk_stat("ret1", 11'h101, 1, 1'b0, 1'b0);
        step(1'b1, OP_RET, 11'h0, 8'h0, 1'b0);
        chk_stat("ret2", 11'h011, 0, 1'b0, 1'b0);
        chk("ret2_empty", 32'(bus.stk_empty), 32'd1);

        // fill: pushes 0x012 then 0x401..0x407
        for (int i = 0; i < 8; i++) begin
            step(1'b1, OP_CALL, 11'(11'h400 + i), 8'h0, 1'b0);
            chk("fill_pc", 32'(bus.pc), 32'(11'h400 + i));
        end
        chk("fill_full", 32'(bus.stk_full), 32'd1);
        chk("fill_empty", 32'(bus.stk_empty), 32'd0);
        step(1'b1, OP_CALL, 11'h300, 8'h0, 1'b0);
        chk_stat("ovf", 11'h408, 8, 1'b1, 1'b0);
        step(1'b0, OP_NEXT, 11'h0, 8'h0, 1'b1);
        chk_stat("ovf_clr", 11'h408, 8, 1'b0, 1'b0);
        for (int i = 7; i >= 1; i--) begin
            step(1'b1, OP_RET, 11'h0, 8'h0, 1'b0);
            chk("lifo_pc", 32'(bus.pc), 32'(11'h400 + i));
            chk("lifo_depth", 32'(bus.depth), 32'(i));
        end
        step(1'b1, OP_RET, 11'h0, 8'h0, 1'b0);
        chk_stat("lifo_last", 11'h012, 0, 1'b0, 1'b0);

        // return address wraps
        step(1'b1, OP_JMP, 11'h7FF, 8'h0, 1'b0);
        step(1'b1, OP_CALL, 11'h050, 8'h0, 1'b0);
        chk_stat("wcall", 11'h050, 1, 1'b0, 1'b0);
        step(1'b1, OP_RET, 11'h0, 8'h0, 1'b0);
        chk_stat("wret", 11'h000, 0, 1'b0, 1'b0);

        step(1'b1, OP_JMP, 11'h020, 8'h0, 1'b0);
        step(1'b1, OP_RET, 11'h0, 8'h0, 1'b0);
        chk_stat("unf", 11'h021, 0, 1'b0, 1'b1);
        step(1'b1, OP_RET, 11'h0, 8'h0, 1'b1);
        chk_stat("unf_setwin", 11'h022, 0, 1'b0, 1'b1);
        step(1'b0, OP_RET, 11'h0, 8'h0, 1'b1);
        chk_stat("unf_clr", 11'h022, 0, 1'b0, 1'b0);

        for (int i = 0; i < 4; i++) begin
            step(1'b0, OP_JMP, 11'h3AA, 8'h0, 1'b0);
            chk_stat("hold", 11'h022, 0, 1'b0, 1'b0);
        end
        step(1'b1, OP_JMP, 11'h3AA, 8'h0, 1'b0);
        chk("jmp_3aa", 32'(bus.pc), 32'h3AA);
        step(1'b1, op_t'(3'd6), 11'h123, 8'h40, 1'b0);
        chk("rsvd6", 32'(bus.pc), 32'h3AB);
        step(1'b1, op_t'(3'd7), 11'h123, 8'h40, 1'b0);
        chk("rsvd7", 32'(bus.pc), 32'h3AC);

        // reset mid-operation empties the stack and clears errors
        step(1'b1, OP_CALL, 11'h155, 8'h0, 1'b0);
        step(1'b1, OP_RET, 11'h0, 8'h0, 1'b0);
        step(1'b1, OP_RET, 11'h0, 8'h0, 1'b0);
        chk_stat("pre_rst", 11'h3AE, 0, 1'b0, 1'b1);
        bus.adv = 1'b1; bus.op = OP_CALL; bus.target = 11'h1AA;
        #2 rst = 1'b0;
        #1;
        chk_stat("mid_rst", 11'h000, 0, 1'b0, 1'b0);
        @(negedge clk);
        rst = 1'b1;
        step(1'b1, OP_CALL, 11'h1AA, 8'h0, 1'b0);
        chk_stat("post_rst", 11'h1AA, 1, 1'b0, 1'b0);
        step(1'b1, OP_RET, 11'h0, 8'h0, 1'b0);
        chk_stat("post_ret", 11'h001, 0, 1'b0, 1'b0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
